// File: rtl/cache_control.sv
// rtl/cache_control.sv - cache control/status register block; CTRL_CNT_EN enables hit/miss counters
module cache_control #(
    parameter int DATA_W      = 32,
    parameter int CTRL_ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [CTRL_ADDR_W-1:0] addr,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    input  logic                   wtbuf_empty,
    input  logic                   wtbuf_full,
    input  logic                   read_hit,
    input  logic                   read_miss,
    input  logic                   write_hit,
    input  logic                   write_miss,
    output logic                   invalidate
);

    localparam logic [CTRL_ADDR_W-1:0] A_WTB_EMPTY  = CTRL_ADDR_W'(1);
    localparam logic [CTRL_ADDR_W-1:0] A_WTB_FULL   = CTRL_ADDR_W'(2);
    localparam logic [CTRL_ADDR_W-1:0] A_RW_HIT     = CTRL_ADDR_W'(3);
    localparam logic [CTRL_ADDR_W-1:0] A_RW_MISS    = CTRL_ADDR_W'(4);
    localparam logic [CTRL_ADDR_W-1:0] A_READ_HIT   = CTRL_ADDR_W'(5);
    localparam logic [CTRL_ADDR_W-1:0] A_READ_MISS  = CTRL_ADDR_W'(6);
    localparam logic [CTRL_ADDR_W-1:0] A_WRITE_HIT  = CTRL_ADDR_W'(7);
    localparam logic [CTRL_ADDR_W-1:0] A_WRITE_MISS = CTRL_ADDR_W'(8);
    localparam logic [CTRL_ADDR_W-1:0] A_RST_CNT    = CTRL_ADDR_W'(9);
    localparam logic [CTRL_ADDR_W-1:0] A_INVALIDATE = CTRL_ADDR_W'(10);

    logic              ready_q;
    logic              invalidate_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              accept;
    logic              clear_cnt;

    // A request held after its acknowledge counts as a new one, hence the ~ready_q term.
    assign accept    = valid & ~ready_q;
    assign clear_cnt = accept & (addr == A_RST_CNT);

`ifdef CTRL_CNT_EN
    logic [DATA_W-1:0] rw_hit_q, rw_miss_q;
    logic [DATA_W-1:0] read_hit_q, read_miss_q, write_hit_q, write_miss_q;

    // Event counters; a clear in the same cycle as an event wins and drops the event.
    always_ff @(posedge clk) begin
        if (reset || clear_cnt) begin
            rw_hit_q     <= '0;
            rw_miss_q    <= '0;
            read_hit_q   <= '0;
            read_miss_q  <= '0;
            write_hit_q  <= '0;
            write_miss_q <= '0;
        end else begin
            rw_hit_q     <= rw_hit_q + DATA_W'(read_hit) + DATA_W'(write_hit);
            rw_miss_q    <= rw_miss_q + DATA_W'(read_miss) + DATA_W'(write_miss);
            read_hit_q   <= read_hit_q + DATA_W'(read_hit);
            read_miss_q  <= read_miss_q + DATA_W'(read_miss);
            write_hit_q  <= write_hit_q + DATA_W'(write_hit);
            write_miss_q <= write_miss_q + DATA_W'(write_miss);
        end
    end
`else
    logic unused_events;
    assign unused_events = ^{read_hit, read_miss, write_hit, write_miss, clear_cnt};
`endif

    // Read mux; counter reads see the pre-increment value, non-accept cycles yield zero.
    always_comb begin
        rdata_d = '0;
        if (accept) begin
            case (addr)
                A_WTB_EMPTY:  rdata_d = {{(DATA_W-1){1'b0}}, wtbuf_empty};
                A_WTB_FULL:   rdata_d = {{(DATA_W-1){1'b0}}, wtbuf_full};
`ifdef CTRL_CNT_EN
                A_RW_HIT:     rdata_d = rw_hit_q;
                A_RW_MISS:    rdata_d = rw_miss_q;
                A_READ_HIT:   rdata_d = read_hit_q;
                A_READ_MISS:  rdata_d = read_miss_q;
                A_WRITE_HIT:  rdata_d = write_hit_q;
                A_WRITE_MISS: rdata_d = write_miss_q;
`else
                A_RW_HIT, A_RW_MISS, A_READ_HIT,
                A_READ_MISS, A_WRITE_HIT, A_WRITE_MISS: rdata_d = '0;
`endif
                default:      rdata_d = '0;
            endcase
        end
    end

    // Handshake and registered outputs; reset drops any pending acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q      <= 1'b0;
            invalidate_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            ready_q      <= accept;
            invalidate_q <= accept & (addr == A_INVALIDATE);
            rdata_q      <= rdata_d;
        end
    end

    assign ready      = ready_q;
    assign invalidate = invalidate_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - self-checking bench for cache_control (honours CTRL_CNT_EN)
module tb_cache_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        wtbuf_empty = 1'b0;
    logic        wtbuf_full = 1'b0;
    logic        read_hit = 1'b0;
    logic        read_miss = 1'b0;
    logic        write_hit = 1'b0;
    logic        write_miss = 1'b0;
    logic        invalidate;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: event tallies since last clear, and whether an ack is outstanding
    logic        mdl_ready = 1'b0;
    logic [31:0] m_rh = '0, m_rm = '0, m_wh = '0, m_wm = '0;
    logic [31:0] exp_rdata;
    logic        exp_ready;
    logic        exp_inv;

    cache_control #(.DATA_W(32), .CTRL_ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr),
        .rdata(rdata), .ready(ready),
        .wtbuf_empty(wtbuf_empty), .wtbuf_full(wtbuf_full),
        .read_hit(read_hit), .read_miss(read_miss),
        .write_hit(write_hit), .write_miss(write_miss),
        .invalidate(invalidate)
    );

    always #5 clk = ~clk;

    // value a read of word a should return given the model's current tallies
    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd1: return {31'b0, wtbuf_empty};
            4'd2: return {31'b0, wtbuf_full};
`ifdef CTRL_CNT_EN
            4'd3: return m_rh + m_wh;
            4'd4: return m_rm + m_wm;
            4'd5: return m_rh;
            4'd6: return m_rm;
            4'd7: return m_wh;
            4'd8: return m_wm;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // drive one cycle of inputs (at negedge), advance the model, return at the next negedge
    task automatic step(input logic rst, input logic v, input logic [3:0] a,
                        input logic rh, input logic rm, input logic wh, input logic wm);
        logic acc;
        reset = rst; valid = v; addr = a;
        read_hit = rh; read_miss = rm; write_hit = wh; write_miss = wm;
        acc       = v && !mdl_ready && !rst;
        exp_rdata = acc ? model_read(a) : 32'd0;
        exp_ready = acc;
        exp_inv   = acc && (a == 4'd10);
        if (rst || (acc && a == 4'd9)) begin
            m_rh = '0; m_rm = '0; m_wh = '0; m_wm = '0;
        end else begin
            m_rh = m_rh + 32'(rh); m_rm = m_rm + 32'(rm);
            m_wh = m_wh + 32'(wh); m_wm = m_wm + 32'(wm);
        end
        mdl_ready = exp_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();
            n_cmp++;
            if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready cyc%0d: got %b want 0", i, ready); end
            n_cmp++;
            if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata cyc%0d: got %0h want 0", i, rdata); end
            n_cmp++;
            if (invalidate !== 1'b0) begin n_bad++; $display("FAIL reset_inv cyc%0d: got %b want 0", i, invalidate); end
        end
    endtask

    task automatic test_status();
        logic [31:0] want [2];
        want[0] = 32'd1; want[1] = 32'd0;
        wtbuf_empty = 1'b1; wtbuf_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (ready !== 1'b1) begin n_bad++; $display("FAIL status_ready addr%0d: got %b want 1", i + 1, ready); end
            n_cmp++;
            if (rdata !== want[i]) begin n_bad++; $display("FAIL status_rdata addr%0d: got %0h want %0h", i + 1, rdata, want[i]); end
            idle();
        end
    endtask

    task automatic test_counters();
        logic [3:0]  ra [6];
        logic [31:0] want [6];
        ra[0] = 4'd3; ra[1] = 4'd5; ra[2] = 4'd7; ra[3] = 4'd4; ra[4] = 4'd6; ra[5] = 4'd8;
`ifdef CTRL_CNT_EN
        want[0] = 32'd5; want[1] = 32'd3; want[2] = 32'd2; want[3] = 32'd1; want[4] = 32'd1; want[5] = 32'd0;
`else
        for (int i = 0; i < 6; i++) want[i] = 32'd0;
`endif
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, ra[i], 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (ready !== 1'b1 || rdata !== want[i])
                begin n_bad++; $display("FAIL counter addr%0d: got rdy=%b %0d want rdy=1 %0d", ra[i], ready, rdata, want[i]); end
            idle();
        end
    endtask

    task automatic test_clear_race();
        step(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (ready !== 1'b1 || rdata !== 32'd0)
            begin n_bad++; $display("FAIL rstcnt_ack: got rdy=%b %0h want rdy=1 0", ready, rdata); end
        idle();
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'd0) begin n_bad++; $display("FAIL clear_race_wh: got %0d want 0", rdata); end
        idle();
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'd0) begin n_bad++; $display("FAIL clear_race_rwh: got %0d want 0", rdata); end
        idle();
    endtask

    task automatic test_invalidate();
        logic seen [4];
        step(1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (invalidate !== 1'b1 || ready !== 1'b1 || rdata !== 32'd0)
            begin n_bad++; $display("FAIL inv_pulse: got inv=%b rdy=%b %0h want 1 1 0", invalidate, ready, rdata); end
        idle();
        n_cmp++;
        if (invalidate !== 1'b0) begin n_bad++; $display("FAIL inv_width: got %b want 0", invalidate); end
        for (int i = 0; i < 4; i++) begin
            seen[i] = ready;
            step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if ({seen[0], seen[1], seen[2], seen[3]} !== 4'b0101)
            begin n_bad++; $display("FAIL hold_pattern: got %b%b%b%b want 0101", seen[0], seen[1], seen[2], seen[3]); end
        idle();
        idle();
    endtask

    task automatic test_events_read();
        logic [31:0] want;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        want = model_read(4'd5);
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== want) begin n_bad++; $display("FAIL rh_after4: got %0d want %0d", rdata, want); end
        idle();
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 0", ready); end
        step(1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ready !== 1'b0 || invalidate !== 1'b0)
            begin n_bad++; $display("FAIL reset_blocks_accept: got rdy=%b inv=%b want 0 0", ready, invalidate); end
        idle();
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_clears_cnt: got %0d want 0", rdata); end
        idle();
    endtask

    task automatic test_random();
        logic v, rst;
        logic [3:0] a;
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 1) == 1);
            a   = 4'($urandom_range(0, 15));
            if (a == 4'd9 && $urandom_range(0, 3) != 0) a = 4'd5;
            rst = ($urandom_range(0, 99) == 0);
            wtbuf_empty = 1'($urandom_range(0, 1));
            wtbuf_full  = 1'($urandom_range(0, 1));
            step(rst, v, a, ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 2));
            n_cmp++;
            if (ready !== exp_ready) begin n_bad++; $display("FAIL rand_ready cyc%0d: got %b want %b", i, ready, exp_ready); end
            n_cmp++;
            if (rdata !== exp_rdata) begin n_bad++; $display("FAIL rand_rdata cyc%0d addr%0d: got %0d want %0d", i, a, rdata, exp_rdata); end
            n_cmp++;
            if (invalidate !== exp_inv) begin n_bad++; $display("FAIL rand_inv cyc%0d: got %b want %b", i, invalidate, exp_inv); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_status();
        test_counters();
        test_clear_race();
        test_invalidate();
        test_events_read();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_control.md
# cache_control

Register-mapped control and status block for the cache, sitting directly downstream of the cache front-end's control port. It consumes the front-end's control-select request (`ctrl_valid`, `ctrl_addr`) and returns `ctrl_rdata`/`ctrl_ready`. It exposes write-through-buffer status, optional hit/miss performance counters, a counter-clear command and a cache-invalidate pulse to the cache memory.

## Interface
Parameters:
- `DATA_W`, 32, width of read data and of each counter.
- `CTRL_ADDR_W`, 4, control word-address width; matches the front-end's `CTRL_ADDR_W`.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `valid` in 1: control request, driven by front-end `ctrl_valid`; held high until `ready`.
- `addr` in `CTRL_ADDR_W`: control word address, from front-end `ctrl_addr`.
- `rdata` out `DATA_W`: read data to front-end `ctrl_rdata`.
- `ready` out 1: one-cycle acknowledge to front-end `ctrl_ready`.
- `wtbuf_empty` in 1: write-through buffer empty flag (level).
- `wtbuf_full` in 1: write-through buffer full flag (level).
- `read_hit`, `read_miss`, `write_hit`, `write_miss` in 1 each: single-cycle event pulses from cache memory.
- `invalidate` out 1: one-cycle pulse that clears all cache valid bits.

## Operation
- Accept condition: `valid & ~ready`. The request is decoded and executed on the accepting cycle. Results are registered.
- Address map (word index):
  - 1 WTB_EMPTY → `{0, wtbuf_empty}`
  - 2 WTB_FULL → `{0, wtbuf_full}`
  - 3 RW_HIT
  - 4 RW_MISS
  - 5 READ_HIT
  - 6 READ_MISS
  - 7 WRITE_HIT
  - 8 WRITE_MISS
  - 9 RST_CNT: clears all counters; `rdata` = 0.
  - 10 INVALIDATE: pulses `invalidate`; `rdata` = 0.
  - All other addresses: `rdata` = 0, no side effect.
- Status reads sample the flag in the accepting cycle.
- Counters are `DATA_W` bits and wrap modulo 2^`DATA_W`; they do not saturate.
  - READ_HIT, READ_MISS, WRITE_HIT, WRITE_MISS each increment by 1 per input pulse.
  - RW_HIT increments by `read_hit + write_hit` (0..2 per cycle); RW_MISS increments by `read_miss + write_miss` (0..2 per cycle).
- Simultaneous events:
  - An RST_CNT accept in the same cycle as an event pulse leaves that counter at 0; clear wins and the event is lost.
  - A counter read in the same cycle as an event returns the pre-increment value.
- No state machine beyond the `ready` toggle. The block is idle whenever `ready` = 0 and `valid` = 0.

## Timing
- Reset values: `ready` = 0, `rdata` = 0, `invalidate` = 0, all counters = 0.
- Latency: `ready` and `rdata` assert exactly 1 cycle after the accepting cycle. `rdata` is valid only while `ready` = 1; it is 0 otherwise.
- `invalidate` is high for exactly the cycle in which `ready` is high for an INVALIDATE access.
- `ready` rule: `ready <= valid & ~ready`. A request held high after its `ready` is treated as a new request on the following cycle, so a continuously held request is served every other cycle.
- `reset` asserted mid-access:
  - the pending `ready`/`invalidate` is dropped (held 0);
  - counters clear;
  - the access is not acknowledged.
- Counter update and RST_CNT clear take effect at the clock edge ending the accepting/event cycle.

## Configuration
- `CTRL_CNT_EN` defined:
  - all six counters are instantiated;
  - addresses 3–8 read the counter values;
  - RST_CNT clears them.
- `CTRL_CNT_EN` undefined:
  - no counter flops exist;
  - addresses 3–8 read 0;
  - RST_CNT is acknowledged with no effect;
  - the hit/miss inputs are unused.
- With the macro undefined, status reads, invalidate and handshake timing are identical to the defined case.

## Test plan
- Reset, then idle for 5 cycles → `ready` = 0, `rdata` = 0, `invalidate` = 0 throughout.
- `wtbuf_empty` = 1, `wtbuf_full` = 0; request addr 1, then addr 2 → `ready` 1 cycle after each accept, `rdata` = 1 then 0.
- With `CTRL_CNT_EN`: 3 `read_hit` pulses, 2 `write_hit` pulses (one in the same cycle as a `read_hit`), 1 `read_miss`; then read addrs 3/5/7/4/6/8 → 5/3/2/1/1/0.
- RST_CNT accepted in the same cycle as a `write_hit` pulse; then read addr 7 → 0. Read addr 3 → 0.
- Request addr 10 → `invalidate` high for exactly 1 cycle, coincident with `ready`, `rdata` = 0. Holding `valid` for 4 cycles → `ready` pattern 0,1,0,1.
- Without `CTRL_CNT_EN`: pulse `read_hit` 4 times, then read addr 5 → `rdata` = 0. Assert `reset` in the cycle after an accept → no `ready` on the next cycle.
